// File: rtl/alu_decoder.sv
// Main-ALU control decoder: maps alu_op/funct to a 4-bit ALU operation plus an illegal flag,
// with registered copies. Define ALU_DEC_SHIFT_EN to decode the SLL/SRL/SRA funct codes.
module alu_decoder (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [3:0] alu_control,
  output logic [3:0] alu_control_q,
  output logic       illegal,
  output logic       illegal_q
);

  localparam logic [1:0] OpMem    = 2'b00;
  localparam logic [1:0] OpBranch = 2'b01;
  localparam logic [1:0] OpRtype  = 2'b10;

  localparam logic [3:0] AluAnd  = 4'b0000;
  localparam logic [3:0] AluOr   = 4'b0001;
  localparam logic [3:0] AluAdd  = 4'b0010;
  localparam logic [3:0] AluXor  = 4'b0011;
  localparam logic [3:0] AluSub  = 4'b0110;
  localparam logic [3:0] AluSlt  = 4'b0111;
  localparam logic [3:0] AluNor  = 4'b1100;
`ifdef ALU_DEC_SHIFT_EN
  localparam logic [3:0] AluSll  = 4'b1000;
  localparam logic [3:0] AluSrl  = 4'b1001;
  localparam logic [3:0] AluSra  = 4'b1010;
`endif
  localparam logic [3:0] AluSltu = 4'b1011;

  localparam logic [5:0] FnAdd  = 6'b100000;
  localparam logic [5:0] FnAddu = 6'b100001;
  localparam logic [5:0] FnSub  = 6'b100010;
  localparam logic [5:0] FnSubu = 6'b100011;
  localparam logic [5:0] FnAnd  = 6'b100100;
  localparam logic [5:0] FnOr   = 6'b100101;
  localparam logic [5:0] FnXor  = 6'b100110;
  localparam logic [5:0] FnNor  = 6'b100111;
  localparam logic [5:0] FnSlt  = 6'b101010;
  localparam logic [5:0] FnSltu = 6'b101011;
`ifdef ALU_DEC_SHIFT_EN
  localparam logic [5:0] FnSll  = 6'b000000;
  localparam logic [5:0] FnSrl  = 6'b000010;
  localparam logic [5:0] FnSra  = 6'b000011;
`endif

  // funct is only examined on the R-type branch, so X/Z on it cannot leak into mem/branch decodes.
  always_comb begin
    alu_control = AluAdd;
    illegal     = 1'b0;
    case (alu_op)
      OpMem:    alu_control = AluAdd;
      OpBranch: alu_control = AluSub;
      OpRtype: begin
        case (funct)
          FnAdd, FnAddu: alu_control = AluAdd;
          FnSub, FnSubu: alu_control = AluSub;
          FnAnd:         alu_control = AluAnd;
          FnOr:          alu_control = AluOr;
          FnXor:         alu_control = AluXor;
          FnNor:         alu_control = AluNor;
          FnSlt:         alu_control = AluSlt;
          FnSltu:        alu_control = AluSltu;
`ifdef ALU_DEC_SHIFT_EN
          FnSll:         alu_control = AluSll;
          FnSrl:         alu_control = AluSrl;
          FnSra:         alu_control = AluSra;
`endif
          default: begin
            alu_control = AluAdd;
            illegal     = 1'b1;
          end
        endcase
      end
      // Reserved class (and unknown alu_op) decodes as ADD and is flagged.
      default: begin
        alu_control = AluAdd;
        illegal     = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_control_q <= AluAdd;
      illegal_q     <= 1'b0;
    end else begin
      alu_control_q <= alu_control;
      illegal_q     <= illegal;
    end
  end

endmodule

// File: tb/tb_alu_decoder.sv
// Self-checking bench for alu_decoder: directed cases plus random alu_op/funct checked
// against a table-driven reference model.
module tb_alu_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] alu_op;
  logic [5:0] funct;
  logic [3:0] alu_control;
  logic [3:0] alu_control_q;
  logic       illegal;
  logic       illegal_q;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] rtype_table [bit [5:0]];
  bit   [5:0] legal_codes [$];

  alu_decoder dut (
    .clk           (clk),
    .rst           (rst),
    .alu_op        (alu_op),
    .funct         (funct),
    .alu_control   (alu_control),
    .alu_control_q (alu_control_q),
    .illegal       (illegal),
    .illegal_q     (illegal_q)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, expected finish before 200000");
    $fatal(1, "timeout");
  end

  // Returns {illegal, alu_control} for an instruction class / funct pair.
  function automatic logic [4:0] model(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'd0) return {1'b0, 4'd2};
    if (op == 2'd1) return {1'b0, 4'd6};
    if (op == 2'd3) return {1'b1, 4'd2};
    if (rtype_table.exists(fn)) return {1'b0, rtype_table[fn]};
    return {1'b1, 4'd2};
  endfunction

  task automatic check(input string tag, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // Drive one pair, check the combinational result, then the registered copy after the edge.
  task automatic apply(input string tag, input logic [1:0] op, input logic [5:0] fn);
    logic [4:0] exp;
    alu_op = op;
    funct  = fn;
    exp    = model(op, (fn === 6'bx) ? 6'd0 : fn);
    #1;
    check({tag, " ctrl"}, alu_control, exp[3:0]);
    check({tag, " ill"}, {3'b0, illegal}, {3'b0, exp[4]});
    @(posedge clk);
    #1;
    check({tag, " ctrl_q"}, alu_control_q, exp[3:0]);
    check({tag, " ill_q"}, {3'b0, illegal_q}, {3'b0, exp[4]});
  endtask

  initial begin
    rtype_table[6'd32] = 4'd2;   // add
    rtype_table[6'd33] = 4'd2;   // addu
    rtype_table[6'd34] = 4'd6;   // sub
    rtype_table[6'd35] = 4'd6;   // subu
    rtype_table[6'd36] = 4'd0;   // and
    rtype_table[6'd37] = 4'd1;   // or
    rtype_table[6'd38] = 4'd3;   // xor
    rtype_table[6'd39] = 4'd12;  // nor
    rtype_table[6'd42] = 4'd7;   // slt
    rtype_table[6'd43] = 4'd11;  // sltu
`ifdef ALU_DEC_SHIFT_EN
    rtype_table[6'd0]  = 4'd8;   // sll
    rtype_table[6'd2]  = 4'd9;   // srl
    rtype_table[6'd3]  = 4'd10;  // sra
`endif
    foreach (rtype_table[k]) legal_codes.push_back(k);

    rst    = 1'b1;
    alu_op = 2'b10;
    funct  = 6'b101010;
    @(posedge clk);
    #1;
    check("reset ctrl_q", alu_control_q, 4'b0010);
    check("reset ill_q", {3'b0, illegal_q}, 4'b0000);
    check("reset comb", alu_control, 4'b0111);
    rst = 1'b0;

    apply("mem fx", 2'b00, 6'bxxxxxx);
    apply("br fx", 2'b01, 6'bxxxxxx);
    apply("r add", 2'b10, 6'b100000);
    apply("r sub", 2'b10, 6'b100010);
    apply("r slt", 2'b10, 6'b101010);
    apply("r and", 2'b10, 6'b100100);
    apply("r or", 2'b10, 6'b100101);
    apply("r nor", 2'b10, 6'b100111);
    apply("r xor", 2'b10, 6'b100110);
    apply("r sltu", 2'b10, 6'b101011);
    apply("r bad", 2'b10, 6'b111111);
    apply("rsvd op", 2'b11, 6'b100000);

    alu_op = 2'b10;
    funct  = 6'b000011;
    #1;
`ifdef ALU_DEC_SHIFT_EN
    check("sra ctrl", alu_control, 4'b1010);
    check("sra ill", {3'b0, illegal}, 4'b0000);
`else
    check("sra ctrl", alu_control, 4'b0010);
    check("sra ill", {3'b0, illegal}, 4'b0001);
`endif

    // Synchronous reset clears only the registered outputs.
    apply("pre rst", 2'b10, 6'b101010);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst ctrl_q", alu_control_q, 4'b0010);
    check("rst ill_q", {3'b0, illegal_q}, 4'b0000);
    check("rst comb", alu_control, 4'b0111);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post rst ctrl_q", alu_control_q, 4'b0111);

    for (int i = 0; i < 300; i++) begin
      logic [1:0] op;
      logic [5:0] fn;
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0)
        fn = legal_codes[$urandom_range(0, legal_codes.size() - 1)];
      else
        fn = 6'($urandom);
      apply("rand", op, fn);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_decoder.md
Name: alu_decoder

Overview:
- Main-ALU control decoder for the single-cycle MIPS datapath.
- Maps the 2-bit alu_op from the main control unit and the R-type funct field to a 4-bit ALU operation code.
- Provides a combinational output for the single-cycle path, a registered copy for pipelined or debug use, and an illegal-funct flag.

Parameters:
- None. Widths are fixed: alu_op 2, funct 6, alu_control 4.

Ports:
- clk  input  1  system clock; all registers update on the rising edge
- rst  input  1  synchronous, active-high reset
- alu_op  input  2  operation class from main control: 00 = load/store, 01 = branch, 10 = R-type, 11 = reserved
- funct  input  6  instruction[5:0]; used only when alu_op = 10
- alu_control  output  4  combinational ALU operation code
- alu_control_q  output  4  alu_control registered on clk
- illegal  output  1  combinational; 1 = unsupported funct or reserved alu_op
- illegal_q  output  1  illegal registered on clk

Behaviour:
- ALU operation encoding:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR
  - 0110 SUB, 0111 SLT, 1100 NOR
  - 1000 SLL, 1001 SRL, 1010 SRA, 1011 SLTU
- Combinational decode, pure function of alu_op and funct, no clock dependency:
  - alu_op = 00 -> 0010 (ADD); funct ignored, including X/Z; illegal = 0.
  - alu_op = 01 -> 0110 (SUB); funct ignored, including X/Z; illegal = 0.
  - alu_op = 11 -> 0010; illegal = 1.
  - alu_op = 10, funct mapping:
    - 100000 ADD and 100001 ADDU -> 0010
    - 100010 SUB and 100011 SUBU -> 0110
    - 100100 -> 0000 (AND)
    - 100101 -> 0001 (OR)
    - 100110 -> 0011 (XOR)
    - 100111 -> 1100 (NOR)
    - 101010 -> 0111 (SLT)
    - 101011 -> 1011 (SLTU)
    - 000000 SLL -> 1000; 000010 SRL -> 1001; 000011 SRA -> 1010 (see Optional Feature)
    - any other funct -> 0010 with illegal = 1
- alu_op X/Z: output is don't-care, but must not latch; implement as a full case with a default.
- Registered outputs:
  - On the rising clk edge with rst = 1: alu_control_q = 0010, illegal_q = 0.
  - Otherwise they capture alu_control and illegal every cycle, giving exactly 1-cycle latency.
  - No enable and no hold state.
- Reset affects only the registered outputs; the combinational outputs stay valid during reset.
- No internal state besides the two output registers.

Optional Feature:
- Macro: ALU_DEC_SHIFT_EN.
- Defined: funct 000000 / 000010 / 000011 with alu_op = 10 decode to SLL / SRL / SRA (1000 / 1001 / 1010), illegal = 0.
- Undefined: those three funct codes fall into the default branch: alu_control = 0010, illegal = 1.
- All other decodes are identical in both builds.

Test Plan:
- alu_op = 00, funct = xxxxxx -> alu_control = 0010, illegal = 0; one clk later alu_control_q = 0010.
- alu_op = 01, funct = xxxxxx -> alu_control = 0110, illegal = 0.
- alu_op = 10 with funct:
  - 100000 -> 0010
  - 100010 -> 0110
  - 101010 -> 0111
  - 100100 -> 0000
  - 100101 -> 0001
  - 100111 -> 1100
  - all with illegal = 0.
- alu_op = 10, funct = 111111 -> 0010, illegal = 1. Also alu_op = 11 -> 0010, illegal = 1. illegal_q follows one cycle later.
- alu_op = 10, funct = 000011 -> with ALU_DEC_SHIFT_EN: 1010, illegal = 0; without it: 0010, illegal = 1.
- Drive funct = 101010 with alu_op = 10, then assert rst for one edge -> alu_control_q = 0010, illegal_q = 0 while alu_control stays 0111. Deassert rst -> alu_control_q = 0111 after the next edge.
